// File: rtl/elastic_fifo_pkg.sv
// Shared constants and the SKIP (K28.0) symbol matcher for the RX elastic buffer.
package elastic_fifo_pkg;

  localparam logic [9:0] SKIP_RD_NEG = 10'h0F4;
  localparam logic [9:0] SKIP_RD_POS = 10'h30B;
  localparam int STATS_WIDTH = 16;

  function automatic logic is_skip(input logic [9:0] sym);
    return (sym == SKIP_RD_NEG) || (sym == SKIP_RD_POS);
  endfunction

endpackage

// File: rtl/elastic_fifo_mem.sv
// Symbol storage: one write port, one registered read port, plus a combinational
// view of the entry at the read address so the top can inspect the head symbol.
module elastic_fifo_mem #(
  parameter int DATA_WIDTH    = 10,
  parameter int BUFFER_DEPTH  = 16,
  parameter int ADDRESS_WIDTH = $clog2(BUFFER_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     rd_en,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic [DATA_WIDTH-1:0]    head
);

  logic [DATA_WIDTH-1:0] mem_reg [BUFFER_DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUFFER_DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  // A simultaneous write to the read address returns the old contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_reg <= '0;
    end else if (rd_en) begin
      rd_data_reg <= mem_reg[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;
  assign head    = mem_reg[rd_addr];

endmodule

// File: rtl/elastic_fifo.sv
// RX elastic buffer with SKIP deletion above the high watermark and SKIP duplication
// below the low watermark. Define ELASTIC_FIFO_STATS_EN to add saturating SKIP counters.
module elastic_fifo
  import elastic_fifo_pkg::*;
#(
  parameter int DATA_WIDTH     = 10,
  parameter int BUFFER_DEPTH   = 16,
  parameter int ADDRESS_WIDTH  = $clog2(BUFFER_DEPTH),
  parameter int LOW_WATERMARK  = 6,
  parameter int HIGH_WATERMARK = 10
) (
  input  logic                   local_clock,
  input  logic                   local_reset,
  input  logic                   wr_en,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic                   rd_en,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   rd_valid,
  output logic [ADDRESS_WIDTH:0] occupancy,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   skip_added,
  output logic                   skip_removed
`ifdef ELASTIC_FIFO_STATS_EN
  ,
  output logic [STATS_WIDTH-1:0] skip_added_count,
  output logic [STATS_WIDTH-1:0] skip_removed_count
`endif
);

  localparam int PW = ADDRESS_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_LVL = PW'(BUFFER_DEPTH);
  localparam logic [PW-1:0] LOW_LVL   = PW'(LOW_WATERMARK);
  localparam logic [PW-1:0] HIGH_LVL  = PW'(HIGH_WATERMARK);

  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg, occupancy_reg, occupancy_next;
  logic          full_reg, empty_reg, ins_done_reg, rd_valid_reg;
  logic          overflow_reg, underflow_reg, skip_added_reg, skip_removed_reg;
  logic          del, ins, pop, push, ovf, unf;
  logic [DATA_WIDTH-1:0] head;

  elastic_fifo_mem #(
    .DATA_WIDTH   (DATA_WIDTH),
    .BUFFER_DEPTH (BUFFER_DEPTH),
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_mem (
    .clk    (local_clock),
    .rst    (local_reset),
    .wr_en  (push),
    .wr_addr(wr_ptr_reg[ADDRESS_WIDTH-1:0]),
    .wr_data(data_in),
    .rd_en  (pop || ins),
    .rd_addr(rd_ptr_reg[ADDRESS_WIDTH-1:0]),
    .rd_data(data_out),
    .head   (head)
  );

  // Deletion is decided first, then insertion, then push/pop, all on pre-edge occupancy.
  always_comb begin
    del = wr_en && is_skip(data_in[9:0]) && (occupancy_reg > HIGH_LVL);
    ins = rd_en && !empty_reg && is_skip(head[9:0]) && (occupancy_reg < LOW_LVL) && !ins_done_reg;
    pop = rd_en && !empty_reg && !ins;
    push = wr_en && !del && (!full_reg || pop);
    ovf = wr_en && !del && full_reg && !pop;
    unf = rd_en && empty_reg;
    occupancy_next = occupancy_reg + PW'(push) - PW'(pop);
  end

  always_ff @(posedge local_clock or posedge local_reset) begin
    if (local_reset) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      occupancy_reg    <= '0;
      full_reg         <= 1'b0;
      empty_reg        <= 1'b1;
      ins_done_reg     <= 1'b0;
      rd_valid_reg     <= 1'b0;
      overflow_reg     <= 1'b0;
      underflow_reg    <= 1'b0;
      skip_added_reg   <= 1'b0;
      skip_removed_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop) begin
        rd_ptr_reg   <= rd_ptr_reg + PW'(1);
        ins_done_reg <= 1'b0;
      end else if (ins) begin
        ins_done_reg <= 1'b1;
      end
      occupancy_reg    <= occupancy_next;
      full_reg         <= (occupancy_next == DEPTH_LVL);
      empty_reg        <= (occupancy_next == '0);
      rd_valid_reg     <= pop || ins;
      overflow_reg     <= ovf;
      underflow_reg    <= unf;
      skip_added_reg   <= ins;
      skip_removed_reg <= del;
    end
  end

  assign rd_valid     = rd_valid_reg;
  assign occupancy    = occupancy_reg;
  assign full         = full_reg;
  assign empty        = empty_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;
  assign skip_added   = skip_added_reg;
  assign skip_removed = skip_removed_reg;

`ifdef ELASTIC_FIFO_STATS_EN
  logic [STATS_WIDTH-1:0] added_count_reg, removed_count_reg;

  always_ff @(posedge local_clock or posedge local_reset) begin
    if (local_reset) begin
      added_count_reg   <= '0;
      removed_count_reg <= '0;
    end else begin
      if (skip_added_reg && (added_count_reg != '1)) added_count_reg <= added_count_reg + 1'b1;
      if (skip_removed_reg && (removed_count_reg != '1)) removed_count_reg <= removed_count_reg + 1'b1;
    end
  end

  assign skip_added_count   = added_count_reg;
  assign skip_removed_count = removed_count_reg;
`endif

endmodule
